// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: fetch handshake between the PC unit (master) and instruction memory (slave).
interface pc_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            fetch_valid;
    logic            fetch_ready;
    logic [XLEN-1:0] pc_address;
    logic [XLEN-1:0] pc_plus_inc;
    modport master(output fetch_valid, pc_address, pc_plus_inc, input fetch_ready);
    modport slave(input fetch_valid, pc_address, pc_plus_inc, output fetch_ready);
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch PC with trap/mret/redirect priority, stall-held redirects and alignment rejection.
module pc_fetch_unit #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_VEC   = '0,
    parameter int              INC         = 4,
    parameter bit              ALIGN_CHECK = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ein,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] mtvec,
    input  logic            mret_valid,
    input  logic [XLEN-1:0] mepc,
    pc_fetch_unit_if.master fetch,
    output logic [XLEN-1:0] pc_prev,
    output logic            misalign,
    output logic [XLEN-1:0] fetch_count
);
    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;
    state_t          state;
    logic            fv, pend_v, pend_trap, new_req, req, is_trap, bad, acc;
    logic [XLEN-1:0] pc, pend_tgt, tgt, pc_inc;
    always_comb begin
        new_req = trap_valid | mret_valid | redir_valid;
        req     = new_req | pend_v;
        tgt     = trap_valid ? mtvec : mret_valid ? mepc : redir_valid ? redir_target : pend_tgt;
        // a held request keeps its trap exemption only if no fresh request overrides it
        is_trap = trap_valid | (!new_req & pend_trap);
        bad     = ALIGN_CHECK & !is_trap & (|tgt[1:0]);
        acc     = fv & fetch.fetch_ready & ein;
        pc_inc  = pc + XLEN'(INC);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= BOOT;
            fv          <= 1'b0;
            pc          <= RESET_VEC;
            pc_prev     <= RESET_VEC;
            fetch_count <= '0;
            misalign    <= 1'b0;
            pend_v      <= 1'b0;
            pend_trap   <= 1'b0;
            pend_tgt    <= '0;
        end else begin
            misalign <= acc & req & bad;
            if (state == BOOT) fv <= 1'b1;
            if (acc) begin
                pc          <= (req & !bad) ? tgt : pc_inc;
                pc_prev     <= pc;
                fetch_count <= fetch_count + XLEN'(1);
                pend_v      <= 1'b0;
                state       <= RUN;
            end else begin
                if (new_req) begin
                    pend_v    <= 1'b1;
                    pend_tgt  <= tgt;
                    pend_trap <= is_trap;
                end
                state <= req ? HOLD : RUN;
            end
        end
    end
    assign fetch.fetch_valid = fv;
    assign fetch.pc_address  = pc;
    assign fetch.pc_plus_inc = pc_inc;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed vectors for the 32-bit unit plus an 8-bit instance for counter wrap.
module tb_pc_fetch_unit;
    logic        clk = 1'b0, reset = 1'b1, rst_b = 1'b1, ein = 1'b0;
    logic        redir_valid = 1'b0, trap_valid = 1'b0, mret_valid = 1'b0;
    logic [31:0] redir_target = '0, mtvec = '0, mepc = '0;
    logic [31:0] pc_prev, fetch_count;
    logic        misalign;
    logic [7:0]  pc_prev_b, fetch_count_b;
    logic        misalign_b;
    int          n = 0, err = 0;
    pc_fetch_unit_if #(.XLEN(32)) fa();
    pc_fetch_unit_if #(.XLEN(8))  fb();
    always #5 clk = ~clk;
    pc_fetch_unit #(.XLEN(32), .RESET_VEC(32'h100)) ua (
        .clk(clk), .reset(reset), .ein(ein),
        .redir_valid(redir_valid), .redir_target(redir_target),
        .trap_valid(trap_valid), .mtvec(mtvec),
        .mret_valid(mret_valid), .mepc(mepc),
        .fetch(fa), .pc_prev(pc_prev), .misalign(misalign), .fetch_count(fetch_count)
    );
    pc_fetch_unit #(.XLEN(8), .RESET_VEC(8'hFC)) ub (
        .clk(clk), .reset(rst_b), .ein(ein),
        .redir_valid(1'b0), .redir_target(8'h0),
        .trap_valid(1'b0), .mtvec(8'h0),
        .mret_valid(1'b0), .mepc(8'h0),
        .fetch(fb), .pc_prev(pc_prev_b), .misalign(misalign_b), .fetch_count(fetch_count_b)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n++;
        if (got !== exp) begin
            err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic redir(input logic [31:0] t);
        redir_valid = 1'b1; redir_target = t;
        step();
        redir_valid = 1'b0;
    endtask
    initial begin
        fa.fetch_ready = 1'b0;
        fb.fetch_ready = 1'b0;
        #12;
        chk("rst fv", fa.fetch_valid, 0);
        chk("rst pc", fa.pc_address, 32'h100);
        chk("rst prev", pc_prev, 32'h100);
        chk("rst cnt", fetch_count, 0);
        chk("rst mis", misalign, 0);
        reset = 1'b0; ein = 1'b1; fa.fetch_ready = 1'b1;
        step();
        chk("boot fv", fa.fetch_valid, 1);
        chk("boot pc", fa.pc_address, 32'h100);
        chk("boot inc", fa.pc_plus_inc, 32'h104);
        step(); chk("run pc1", fa.pc_address, 32'h104);
        step(); chk("run pc2", fa.pc_address, 32'h108);
        step(); chk("run pc3", fa.pc_address, 32'h10C);
        chk("run cnt3", fetch_count, 3);
        chk("run prev3", pc_prev, 32'h108);
        step();
        chk("run cnt4", fetch_count, 4);
        chk("run prev4", pc_prev, 32'h10C);
        chk("run pc4", fa.pc_address, 32'h110);
        redir(32'h200);
        chk("redir pc", fa.pc_address, 32'h200);
        trap_valid = 1'b1; mret_valid = 1'b1; redir_valid = 1'b1;
        mtvec = 32'h80; mepc = 32'h300; redir_target = 32'h400;
        step();
        chk("prio trap", fa.pc_address, 32'h80);
        trap_valid = 1'b0;
        step();
        chk("prio mret", fa.pc_address, 32'h300);
        chk("prio prev", pc_prev, 32'h80);
        mret_valid = 1'b0; redir_valid = 1'b0;
        redir(32'h40);
        fa.fetch_ready = 1'b0;
        redir(32'h500);
        chk("stall pc1", fa.pc_address, 32'h40);
        chk("stall fv", fa.fetch_valid, 1);
        step(); chk("stall pc2", fa.pc_address, 32'h40);
        step(); chk("stall pc3", fa.pc_address, 32'h40);
        chk("stall cnt", fetch_count, 8);
        fa.fetch_ready = 1'b1;
        step();
        chk("pend pc", fa.pc_address, 32'h500);
        chk("pend prev", pc_prev, 32'h40);
        chk("pend cnt", fetch_count, 9);
        step();
        chk("pend clr", fa.pc_address, 32'h504);
        redir(32'h10);
        redir(32'h502);
        chk("mis pc", fa.pc_address, 32'h14);
        chk("mis pulse", misalign, 1);
        chk("mis cnt", fetch_count, 12);
        chk("mis prev", pc_prev, 32'h10);
        step();
        chk("mis end", misalign, 0);
        chk("mis pc2", fa.pc_address, 32'h18);
        fa.fetch_ready = 1'b0;
        redir(32'h503);
        chk("pmis hold", misalign, 0);
        chk("pmis pc", fa.pc_address, 32'h18);
        fa.fetch_ready = 1'b1;
        step();
        chk("pmis pulse", misalign, 1);
        chk("pmis pc2", fa.pc_address, 32'h1C);
        trap_valid = 1'b1; mtvec = 32'h82;
        step();
        trap_valid = 1'b0;
        chk("trap noalign", fa.pc_address, 32'h82);
        chk("trap nomis", misalign, 0);
        redir(32'hFFFF_FFFC);
        chk("wrap inc", fa.pc_plus_inc, 32'h0);
        step();
        chk("wrap pc", fa.pc_address, 32'h0);
        fa.fetch_ready = 1'b0;
        redir(32'h700);
        #2 reset = 1'b1;
        #1;
        chk("arst pc", fa.pc_address, 32'h100);
        chk("arst fv", fa.fetch_valid, 0);
        chk("arst cnt", fetch_count, 0);
        chk("arst prev", pc_prev, 32'h100);
        reset = 1'b0; fa.fetch_ready = 1'b1;
        step();
        chk("arst first", fa.pc_address, 32'h100);
        step();
        chk("arst nopend", fa.pc_address, 32'h104);
        rst_b = 1'b0; fb.fetch_ready = 1'b1;
        step();
        chk("b fv", fb.fetch_valid, 1);
        step();
        chk("b pcwrap", fb.pc_address, 0);
        for (int i = 0; i < 254; i++) step();
        chk("b cnt ff", fetch_count_b, 8'hFF);
        step();
        chk("b cntwrap", fetch_count_b, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n, err);
        $finish;
    end
endmodule
